// File: rtl/fetch_queue_stage.sv
// Fetch stage: sequential group-PC generator with credit-limited I$ requests,
// an in-order response queue feeding decode, and epoch-tagged redirect squash.
module fetch_queue_stage #(
  parameter int              SUPER     = 4,
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter int              EPOCH_W   = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    icache_req_valid,
  input  logic                    icache_req_ready,
  output logic [XLEN-1:0]         icache_req_pc,
  output logic [EPOCH_W-1:0]      icache_req_tag,
  input  logic                    icache_resp_valid,
  input  logic [XLEN-1:0]         icache_resp_pc,
  input  logic [EPOCH_W-1:0]      icache_resp_tag,
  input  logic [SUPER*XLEN-1:0]   icache_resp_data,
  input  logic [SUPER-1:0]        icache_resp_mask,
  output logic [SUPER-1:0]        dec_valid,
  output logic [SUPER*XLEN-1:0]   dec_pc,
  output logic [SUPER*XLEN-1:0]   dec_instr,
  input  logic                    dec_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(DEPTH + MAX_OUTST + 1);

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]      outst_q, outst_d;

  logic [XLEN-1:0]       q_pc   [DEPTH];
  logic [SUPER*XLEN-1:0] q_data [DEPTH];
  logic [SUPER-1:0]      q_mask [DEPTH];

  logic [SW-1:0] inflight;
  logic can_req, req_fire, push, pop, dec_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queue slots already reserved by in-flight requests count against capacity,
  // so an accepted response always has room.
  assign inflight = SW'(count_q) + SW'(outst_q);
  assign can_req  = !redirect_valid && (inflight < SW'(DEPTH)) && (outst_q < OW'(MAX_OUTST));
  assign req_fire = can_req && icache_req_ready;
  assign push     = icache_resp_valid && (icache_resp_tag == epoch_q) && !redirect_valid;
  assign pop      = dec_ready && (count_q != '0) && !redirect_valid;
  assign dec_ok   = !rst && (count_q != '0);

  assign icache_req_valid = !rst && can_req;
  assign icache_req_pc    = rst ? '0 : fetch_pc_q;
  assign icache_req_tag   = rst ? '0 : epoch_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q;
    unique case ({req_fire, icache_resp_valid})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = epoch_q + EPOCH_W'(1);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4 * SUPER);
      if (push)     tail_d = ptr_inc(tail_q);
      if (pop)      head_d = ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      outst_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q    <= epoch_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      outst_q    <= outst_d;
    end
  end

  // Storage needs no reset: it is only observed through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail_q]   <= icache_resp_pc;
      q_data[tail_q] <= icache_resp_data;
      q_mask[tail_q] <= icache_resp_mask;
    end
  end

  for (genvar i = 0; i < SUPER; i++) begin : g_slot
    assign dec_valid[i]               = dec_ok && q_mask[head_q][i];
    assign dec_pc[i*XLEN +: XLEN]     = dec_ok ? q_pc[head_q] + XLEN'(4 * i) : '0;
    assign dec_instr[i*XLEN +: XLEN]  = dec_ok ? q_data[head_q][i*XLEN +: XLEN] : '0;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count_q == CW'(DEPTH)));

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the single-register fetch stage. Generates sequential fetch-group PCs and issues them to the I$ over a valid/ready request channel. Accepts in-order tagged I$ responses and buffers them in a DEPTH-entry fetch queue feeding decode. Supports redirect with epoch-based squash of in-flight responses.

Parameters:
SUPER, 4, instructions per fetch group (power of 2, >=1)
XLEN, 32, PC and instruction width in bits
DEPTH, 4, fetch-queue capacity in groups (>=2)
MAX_OUTST, 2, maximum in-flight I$ requests (>=1)
EPOCH_W, 2, epoch tag width; 2^EPOCH_W must exceed MAX_OUTST
RESET_PC, 0, PC loaded at reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
redirect_valid  in  1  redirect request from decode/backend
redirect_pc  in  XLEN  redirect target
icache_req_valid  out  1  request valid
icache_req_ready  in  1  I$ accepts request
icache_req_pc  out  XLEN  group start PC
icache_req_tag  out  EPOCH_W  current epoch
icache_resp_valid  in  1  response valid (no backpressure)
icache_resp_pc  in  XLEN  echoed group PC
icache_resp_tag  in  EPOCH_W  echoed epoch
icache_resp_data  in  SUPER*XLEN  instruction words, slot i at bits [i*XLEN +: XLEN]
icache_resp_mask  in  SUPER  per-slot valid
dec_valid  out  SUPER  per-slot valid of head group
dec_pc  out  SUPER*XLEN  slot PCs
dec_instr  out  SUPER*XLEN  slot instructions
dec_ready  in  1  decode consumes entire head group

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, epoch=0, queue empty, outst=0. All outputs 0 while rst is high.
- Group PCs: slot i PC = group_pc + 4*i, XLEN-bit modulo arithmetic. next fetch_pc = fetch_pc + 4*SUPER (wraps).
- Credit rule: icache_req_valid = !redirect_valid && (count + outst) < DEPTH && outst < MAX_OUTST. req_pc = fetch_pc, req_tag = epoch.
- Request handshake (valid && ready): fetch_pc advances by 4*SUPER and outst increments. Holding: req_pc/req_tag are stable while valid && !ready.
- Response: always accepted; outst decrements every response cycle. If resp_tag==epoch and no redirect this cycle, write {resp_pc, data, mask} to queue tail; otherwise drop.
- Simultaneous request handshake and response: outst is unchanged.
- Queue: circular, DEPTH entries, count 0..DEPTH. Overflow cannot occur under the credit rule; a push at count==DEPTH is a verification assertion failure.
- Decode output: dec_valid[i] = (count!=0) && head.mask[i]. dec_pc/dec_instr come from the head entry and are 0 when empty.
- Pop when dec_ready && count!=0. Simultaneous push and pop leaves count unchanged.
- Latency: response at edge t is visible on dec_* after edge t (one registered stage, no bypass). Request to earliest decode is I$ latency + 1.
- Redirect (cycle with redirect_valid=1):
  - queue flushed (count=0, head=tail), fetch_pc<=redirect_pc, epoch<=epoch+1 (mod 2^EPOCH_W).
  - no request issued, no pop, any same-cycle response dropped.
  - outst is not cleared; stale responses drain via the tag mismatch.
- Back-to-back redirects: each increments epoch; the last target wins.
- Reset mid-operation: all state returns to reset values immediately. The I$ must discard its in-flight requests on the same rst.

Test Plan:
- Reset/sequential: SUPER=4, RESET_PC=0x100, req_ready=1, 1-cycle I$ echoing, dec_ready=1 -> req_pc 0x100,0x110,0x120...; dec_pc slots 0x100/0x104/0x108/0x10C one cycle after the first response.
- Backpressure: dec_ready=0 -> exactly DEPTH=4 requests accepted, then req_valid=0. One dec_ready pulse -> one pop and one new request next cycle.
- Redirect squash: 2 requests in flight with tag 0, redirect_pc=0x400 -> queue empty, next req_pc=0x400 tag 1. Both tag-0 responses dropped and outst returns to 0.
- Partial mask: resp_mask=4'b0011 -> dec_valid=4'b0011, upper slots ignored.
- Redirect coincident with a matching response and dec_ready=1 -> response dropped, no pop, no request that cycle.
- PC wrap: fetch_pc=0xFFFF_FFF0 with SUPER=4 -> next req_pc=0x0000_0000. Async rst asserted mid-stream -> outputs 0 immediately, req_pc=RESET_PC after release.
